// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register-file responder with independent write (AW/W/B) and read (AR/R) paths.
// Build option: define AXIL_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module axi4lite_reg_slave #(
  parameter int unsigned            ADDR_WIDTH = 2,
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            REG_COUNT  = 4,
  parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  localparam int unsigned NumSlots = 2 ** ADDR_WIDTH;
  localparam logic [1:0]  RespOkay = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0]  RespUnmapped = 2'b10;
`else
  localparam logic [1:0]  RespUnmapped = 2'b00;
`endif

  // One bit per address slot: set where a register is implemented.
  logic [NumSlots-1:0] map_mask;
  for (genvar i = 0; i < NumSlots; i++) begin : g_map
    assign map_mask[i] = (i < REG_COUNT);
  end

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs, w_hs, commit, wr_mapped;

  // Readies are forced low while reset is asserted and track buffer state otherwise.
  assign s_awready = rst_n & ~aw_held_q & ~bvalid_q;
  assign s_wready  = rst_n & ~w_held_q & ~bvalid_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;

  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;
  assign commit    = aw_held_q & w_held_q;
  assign wr_mapped = map_mask[aw_addr_q];

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_mapped ? RespOkay : RespUnmapped;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_addr_d = s_awaddr;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = s_wdata;
      end
    end
    if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Unmapped addresses match no slot below, so the write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (commit) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (aw_addr_q == ADDR_WIDTH'(i)) begin
          regs_q[i] <= w_data_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  ar_hs, rd_mapped;

  assign s_arready = rst_n & ~rvalid_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  assign ar_hs     = s_arvalid & s_arready;
  assign rd_mapped = map_mask[s_araddr];

  // Samples the register array before any same-edge commit lands.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (s_araddr == ADDR_WIDTH'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_mapped ? RespOkay : RespUnmapped;
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule
